// File: rtl/addsub_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : addsub_multicycle
// Description : Multi-cycle WIDTH-bit add/subtract unit for the Execute-stage
//               ALU. Each RUN cycle handles CHUNK bits, so one operation takes
//               N = WIDTH/CHUNK cycles. The unit also produces the ZF, SF and
//               OF flags and the raw carry out of the MSB.
//
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous active-low reset
//               start      - request, sampled only in IDLE or DONE
//               op         - 0 = a + b, 1 = a - b (latched with start)
//               a, b       - operands (latched with start)
//               busy       - high while the operation is in RUN
//               done       - one-cycle pulse; outputs below update with it
//               result     - sum or difference, modulo 2^WIDTH
//               carry_out  - carry out of MSB (subtract: 1 = no borrow)
//               ovf        - two's-complement signed overflow
//               zf         - result == 0
//               sf         - result[WIDTH-1]
//
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_multicycle #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovf,
    output logic             zf,
    output logic             sf
);

    localparam int c_num_chunks = WIDTH / CHUNK;
    localparam int c_cnt_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_num_chunks - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Reject parameter sets that would leave a partial top chunk.
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("addsub_multicycle: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;       // already inverted for subtract
    logic               r_carry;
    logic [WIDTH-1:0]   r_work;    // partial result, separate from result

    logic [31:0]        w_base;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK:0]     w_sum;
    logic [WIDTH-1:0]   w_final;
    logic               w_accept;
    logic               w_last;
    logic               w_ovf;

    assign w_base    = 32'(r_cnt) * 32'(CHUNK);
    assign w_a_chunk = r_a[w_base +: CHUNK];
    assign w_b_chunk = r_b[w_base +: CHUNK];
    assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

    // Working register with the current chunk merged in. On the last chunk
    // this is the complete result, so flags can be derived from it directly.
    always_comb begin
        w_final                  = r_work;
        w_final[w_base +: CHUNK] = w_sum[CHUNK-1:0];
    end

    assign w_accept = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_last   = (r_cnt == c_last_cnt);
    // Same operand signs but a different result sign means signed overflow.
    assign w_ovf    = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_final[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_work    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
            zf        <= 1'b0;
            sf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= op ? ~b : b;
                        // Carry-in of 1 turns a + ~b into a - b.
                        r_carry <= op;
                        r_cnt   <= '0;
                        r_state <= c_st_run;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= c_st_idle;
                        busy    <= 1'b0;
                    end
                end

                c_st_run: begin
                    r_work  <= w_final;
                    r_carry <= w_sum[CHUNK];
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_state   <= c_st_done;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= w_final;
                        carry_out <= w_sum[CHUNK];
                        ovf       <= w_ovf;
                        zf        <= ~|w_final;
                        sf        <= w_final[WIDTH-1];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_multicycle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_addsub_multicycle
// Description : Scoreboard bench for addsub_multicycle. Three instances
//               (CHUNK = 8, 64, 1) share operands; each is exercised in turn
//               with hand-computed vectors, back-to-back, ignored-start and
//               mid-operation reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_multicycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic        op;
    logic [63:0] a;
    logic [63:0] b;

    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    logic [2:0]  co_w;
    logic [2:0]  ov_w;
    logic [2:0]  zf_w;
    logic [2:0]  sf_w;
    logic [63:0] res_w [3];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_multicycle #(.WIDTH(64), .CHUNK(8)) u_dut_c8 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .op(op), .a(a), .b(b),
        .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]), .carry_out(co_w[0]),
        .ovf(ov_w[0]), .zf(zf_w[0]), .sf(sf_w[0])
    );
    addsub_multicycle #(.WIDTH(64), .CHUNK(64)) u_dut_c64 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .op(op), .a(a), .b(b),
        .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]), .carry_out(co_w[1]),
        .ovf(ov_w[1]), .zf(zf_w[1]), .sf(sf_w[1])
    );
    addsub_multicycle #(.WIDTH(64), .CHUNK(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .op(op), .a(a), .b(b),
        .busy(busy_w[2]), .done(done_w[2]), .result(res_w[2]), .carry_out(co_w[2]),
        .ovf(ov_w[2]), .zf(zf_w[2]), .sf(sf_w[2])
    );

    typedef struct packed {
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        s;
    } vec_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [63:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        s;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];
    int   busy_cnt [3];
    int   errors = 0;
    int   checks = 0;

    // Cycles from accept to done for each instance.
    function automatic int lat(input int d);
        case (d)
            0:       return 8;
            1:       return 1;
            default: return 64;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard whenever any instance pulses done.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        for (int d = 0; d < 3; d++) busy_cnt[d] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (done_w[d]) begin
                    if (sb.size() == 0) begin
                        check($sformatf("c%0d spurious_done", lat(d)), 64'(done_w[d]), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("c%0d latency_cycle", lat(d)), 64'(cyc), 64'(e.cyc));
                        check($sformatf("c%0d result", lat(d)), res_w[d], e.res);
                        check($sformatf("c%0d carry_out", lat(d)), 64'(co_w[d]), 64'(e.c));
                        check($sformatf("c%0d ovf", lat(d)), 64'(ov_w[d]), 64'(e.v));
                        check($sformatf("c%0d zf", lat(d)), 64'(zf_w[d]), 64'(e.z));
                        check($sformatf("c%0d sf", lat(d)), 64'(sf_w[d]), 64'(e.s));
                        check($sformatf("c%0d busy_at_done", lat(d)), 64'(busy_w[d]), 64'd0);
                        check($sformatf("c%0d busy_cycles", lat(d)), 64'(busy_cnt[d]), 64'(lat(d)));
                    end
                    busy_cnt[d] = 0;
                end else if (busy_w[d]) begin
                    busy_cnt[d]++;
                end else begin
                    busy_cnt[d] = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (call right after a negedge).
    // ------------------------------------------------------------------
    task automatic push_exp(input int d, input int vi);
        exp_t e;
        e.cyc = 32'(cyc + 1 + lat(d));
        e.res = vecs[vi].res;
        e.c   = vecs[vi].c;
        e.v   = vecs[vi].v;
        e.z   = vecs[vi].z;
        e.s   = vecs[vi].s;
        sb.push_back(e);
    endtask

    task automatic drive(input int d, input int vi);
        a        = vecs[vi].a;
        b        = vecs[vi].b;
        op       = vecs[vi].op;
        start[d] = 1'b1;
        push_exp(d, vi);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0) && (n < 200)) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout pending_entries", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        check($sformatf("c%0d %s result", lat(d), tag), res_w[d], 64'd0);
        check($sformatf("c%0d %s carry_out", lat(d), tag), 64'(co_w[d]), 64'd0);
        check($sformatf("c%0d %s ovf", lat(d), tag), 64'(ov_w[d]), 64'd0);
        check($sformatf("c%0d %s zf", lat(d), tag), 64'(zf_w[d]), 64'd0);
        check($sformatf("c%0d %s sf", lat(d), tag), 64'(sf_w[d]), 64'd0);
        check($sformatf("c%0d %s busy", lat(d), tag), 64'(busy_w[d]), 64'd0);
        check($sformatf("c%0d %s done", lat(d), tag), 64'(done_w[d]), 64'd0);
    endtask

    task automatic run_suite(input int d);
        int n;
        // Plain vectors, one at a time.
        for (int vi = 0; vi < 8; vi++) begin
            @(negedge clk);
            drive(d, vi);
            @(negedge clk);
            start[d] = 1'b0;
            wait_drain();
        end

        // Start held high through DONE: second op accepted on the DONE edge.
        @(negedge clk);
        drive(d, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_w[d] && (n < 200));
        if (!done_w[d]) check($sformatf("c%0d b2b_done_timeout", lat(d)), 64'(done_w[d]), 64'd1);
        drive(d, 2);
        @(negedge clk);
        start[d] = 1'b0;
        wait_drain();

        // Start pulsed in RUN with different operands must be ignored.
        @(negedge clk);
        drive(d, 0);
        @(negedge clk);
        a  = 64'd1;
        b  = 64'd1;
        op = 1'b0;
        @(negedge clk);
        start[d] = 1'b0;
        wait_drain();

        // Reset at cnt=3 aborts the operation with no done pulse.
        if (lat(d) > 4) begin
            @(negedge clk);
            a        = vecs[5].a;
            b        = vecs[5].b;
            op       = vecs[5].op;
            start[d] = 1'b1;
            @(negedge clk);
            start[d] = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_zero(d, "after_abort");
            repeat (lat(d) + 4) @(negedge clk);
            drive(d, 3);
            @(negedge clk);
            start[d] = 1'b0;
            wait_drain();
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        vecs[0] = '{1'b1, 64'd9, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                    64'hE1E1_E1E1_E1E1_E1E1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 64'd100, 64'd50, 64'd50, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 64'd50, 64'd100, 64'hFFFF_FFFF_FFFF_FFCE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000,
                    1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
                    1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 3'b000;
        op    = 1'b0;
        a     = 64'd0;
        b     = 64'd0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_zero(d, "reset");
        rst_n = 1'b1;

        for (int d = 0; d < 3; d++) run_suite(d);

        repeat (5) @(negedge clk);
        wait_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
